// File: rtl/temp_seg7_scan_pkg.sv
// -----------------------------------------------------------------------------
// temp_seg7_pkg
//   Shared constants for the temperature 7-segment scanner:
//   - active-high segment codes (bit0..bit6 = a..g) for numerals, 'E',
//     minus and blank, plus the decimal-point bit position in the 8-bit
//     seg bus;
//   - digit slot indices (slot 0 is the rightmost digit);
//   - the per-slot scan state type.
// -----------------------------------------------------------------------------
package temp_seg7_pkg;

    // Segment codes, active-high, a = bit0 .. g = bit6.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Decimal point position on the 8-bit seg bus.
    localparam int SEG_DP_BIT = 7;

    // Digit slot indices; slot n drives dig[n].
    localparam logic [1:0] IDX_TENTHS = 2'd0;
    localparam logic [1:0] IDX_UNITS  = 2'd1;
    localparam logic [1:0] IDX_TENS   = 2'd2;
    localparam logic [1:0] IDX_SIGN   = 2'd3;

    // Within each slot: dead time first, then the digit is driven.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage : temp_seg7_pkg

// File: rtl/temp_seg7_scan_seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
//   Combinational nibble -> 7-segment decoder (active-high).
//   Nibbles 10..15 are not valid packed digits and display as 'E' so an
//   overflowed upstream digit is visible rather than silently wrong.
//
// Ports:
//   nibble  in  [3:0]  packed decimal digit
//   code    out [6:0]  segments a..g (bit0..bit6), active-high
// -----------------------------------------------------------------------------
module seg7_encode
    import temp_seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_E;
        case (nibble)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_E;
        endcase
    end

endmodule : seg7_encode

// File: rtl/temp_seg7_scan.sv
// -----------------------------------------------------------------------------
// temp_seg7_scan
//   Time-multiplexes a packed temperature word (sign, tens, units, tenths)
//   onto a 4-digit common-anode 7-segment display.
//
//   A slot counter (cnt) runs 0..SLOT_CYCLES-1; at each wrap the digit
//   index (idx) advances 0..3. Each slot opens with BLANK_CYCLES of dead
//   time (everything off) to stop ghosting, then drives one digit. The
//   input word is snapshotted once per frame, at the very last cycle of
//   the sign slot, so a frame always shows one consistent value.
//   seg, dig and frame_tick are registered and lag cnt/idx by one clock.
//
// Ports:
//   clk          in       system clock
//   rst          in       synchronous, active-high reset
//   temperature  in  [15:0] [15:12] sign, [11:8] tens, [7:4] units, [3:0] tenths
//   seg          out [7:0]  bit0..6 = a..g, bit7 = dp; inverted if SEG_ACTIVE_LOW
//   dig          out [3:0]  dig[0] tenths .. dig[3] sign; inverted if DIG_ACTIVE_LOW
//   frame_tick   out        one-cycle pulse on the cycle after the snapshot reload
// -----------------------------------------------------------------------------
module temp_seg7_scan
    import temp_seg7_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] temperature,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_tick
);

    localparam int SLOT_CYCLES = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNT_W       = $clog2(SLOT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // XOR masks: the "all off" pattern doubles as the polarity inversion.
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF  : 4'h0;

    // cnt resets to 0, which is a blank cycle unless the dead time is zero.
    localparam scan_state_e RESET_STATE = (BLANK_CYCLES != 0) ? ST_BLANK : ST_DRIVE;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    scan_state_e      state_q, state_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       dig_q, dig_d;
    logic             frame_tick_q, frame_tick_d;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       enc_nibble;
    logic [6:0]       enc_code;
    logic [7:0]       digit_code;

    // ---------------------------------------------------------------------
    // Process 1: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= IDX_TENTHS;
            snap_q       <= 16'h0000;
            state_q      <= RESET_STATE;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            state_q      <= state_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // ---------------------------------------------------------------------
    // Process 2: next-state logic (counter, index, snapshot, slot phase)
    // ---------------------------------------------------------------------
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_SIGN);

        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
        snap_d       = frame_end ? temperature : snap_q;
        frame_tick_d = frame_end;

        // Phase follows the counter value it will hold next cycle, so
        // state_q always agrees with cnt_q.
        if ((BLANK_CYCLES != 0) && (cnt_d < BLANK_END)) begin
            state_d = ST_BLANK;
        end else begin
            state_d = ST_DRIVE;
        end
    end

    // ---------------------------------------------------------------------
    // Digit selection and encoding (single shared decoder)
    // ---------------------------------------------------------------------
    always_comb begin
        enc_nibble = snap_q[3:0];
        case (idx_q)
            IDX_TENTHS: enc_nibble = snap_q[3:0];
            IDX_UNITS:  enc_nibble = snap_q[7:4];
            IDX_TENS:   enc_nibble = snap_q[11:8];
            default:    enc_nibble = snap_q[15:12];
        endcase
    end

    seg7_encode u_encode (
        .nibble (enc_nibble),
        .code   (enc_code)
    );

    always_comb begin
        digit_code = {1'b0, SEG_BLANK};
        case (idx_q)
            IDX_TENTHS: digit_code = {1'b0, enc_code};
            // Units carries the decimal point: "23.5".
            IDX_UNITS:  digit_code = {1'b1, enc_code};
            // Leading-zero blanking on the tens digit.
            IDX_TENS:   digit_code = (snap_q[11:8] == 4'd0) ? {1'b0, SEG_BLANK}
                                                            : {1'b0, enc_code};
            // Sign nibble is a flag, not a numeral: 0 blank, 1 minus, else 'E'.
            default: begin
                if (snap_q[15:12] == 4'd0) begin
                    digit_code = {1'b0, SEG_BLANK};
                end else if (snap_q[15:12] == 4'd1) begin
                    digit_code = {1'b0, SEG_MINUS};
                end else begin
                    digit_code = {1'b0, SEG_E};
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Process 3: output logic (registered one clock behind cnt/idx)
    // ---------------------------------------------------------------------
    always_comb begin
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (state_q == ST_DRIVE) begin
            seg_d = digit_code ^ SEG_OFF;
            dig_d = (4'b0001 << idx_q) ^ DIG_OFF;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_tick = frame_tick_q;

endmodule : temp_seg7_scan

// File: tb/tb_temp_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_temp_seg7_scan
//   Two instances share rst/temperature: one with a 2-cycle dead time and
//   one with none. A cycle-count model derives every expected output from
//   the global cycle number since reset and the list of per-frame
//   snapshots, and is compared against both instances on every negedge.
// -----------------------------------------------------------------------------
module tb_temp_seg7_scan;

    localparam int SLOT  = 10;
    localparam int FRAME = 4 * SLOT;
    localparam int BLANK = 2;

    // ---------------------------------------------------------------------
    // Clock / reset / DUTs
    // ---------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] temperature = 16'h0000;
    logic [7:0]  seg, seg0;
    logic [3:0]  dig, dig0;
    logic        frame_tick, frame_tick0;

    always #5 clk = ~clk;

    temp_seg7_scan #(
        .CLK_FREQ_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .temperature(temperature),
        .seg(seg), .dig(dig), .frame_tick(frame_tick)
    );

    temp_seg7_scan #(
        .CLK_FREQ_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(0),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .temperature(temperature),
        .seg(seg0), .dig(dig0), .frame_tick(frame_tick0)
    );

    // ---------------------------------------------------------------------
    // Scoreboard counters
    // ---------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t cyc=%0d got=%0h exp=%0h", name, $time, cyc, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: cycle number since reset + snapshot per frame
    // ---------------------------------------------------------------------
    int          cyc = 0;
    logic [15:0] snaps[$];
    bit          checking = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0;
            snaps.delete();
        end else begin
            if (cyc % FRAME == FRAME - 1) snaps.push_back(temperature);
            cyc <= cyc + 1;
        end
    end

    localparam logic [6:0] NUM_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] numeral(input logic [3:0] n);
        if (n > 4'd9) return 7'h79;
        return NUM_TAB[n];
    endfunction

    // Active-high 8-bit pattern for digit position idx of a word.
    function automatic logic [7:0] raw_code(input int idx, input logic [15:0] w);
        case (idx)
            0: return {1'b0, numeral(w[3:0])};
            1: return {1'b1, numeral(w[7:4])};
            2: return (w[11:8] == 4'd0) ? 8'h00 : {1'b0, numeral(w[11:8])};
            default: begin
                if (w[15:12] == 4'd0) return 8'h00;
                if (w[15:12] == 4'd1) return 8'h40;
                return 8'h79;
            end
        endcase
    endfunction

    // Outputs seen during cycle c describe scan position c-1.
    task automatic model(input int c, input int blank,
                         output logic [7:0] e_seg, output logic [3:0] e_dig,
                         output logic e_ft);
        int p, pos, idx, f;
        logic [15:0] w;
        logic [3:0]  one;
        e_seg = 8'hFF;
        e_dig = 4'hF;
        e_ft  = 1'b0;
        if (c >= 1) begin
            p   = c - 1;
            pos = p % SLOT;
            idx = (p / SLOT) % 4;
            f   = p / FRAME;
            w   = (f == 0) ? 16'h0000 : snaps[f-1];
            e_ft = (p % FRAME == FRAME - 1);
            if (pos >= blank) begin
                one   = 4'b0001 << idx;
                e_seg = ~raw_code(idx, w);
                e_dig = ~one;
            end
        end
    endtask

    // Compare process: every cycle, both instances.
    always @(negedge clk) begin
        logic [7:0] es;
        logic [3:0] ed;
        logic       ef;
        if (checking) begin
            model(cyc, BLANK, es, ed, ef);
            chk("seg", seg, es);
            chk("dig", dig, ed);
            chk("frame_tick", frame_tick, ef);
            model(cyc, 0, es, ed, ef);
            chk("seg_noblank", seg0, es);
            chk("dig_noblank", dig0, ed);
            chk("frame_tick_noblank", frame_tick0, ef);
            if (cyc >= 1) chk("dig_noblank_onehot", $countones(~dig0), 1);
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic wait_cycle(input int target);
        int n = 0;
        while (cyc != target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cycle_reached", cyc, target);
    endtask

    task automatic lit(input string name, input logic [7:0] s, input logic [3:0] d);
        chk({name, "_seg"}, seg, s);
        chk({name, "_dig"}, dig, d);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        temperature = 16'h0235;
        rst = 1'b1;
        @(posedge clk);
        #1 checking = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Frame 0 shows the reset snapshot 0000.
        wait_cycle(1);
        lit("f0_blank", 8'hFF, 4'hF);
        chk("f0_noblank_seg", seg0, 8'hC0);
        chk("f0_noblank_dig", dig0, 4'hE);
        wait_cycle(6);   lit("f0_tenths", 8'hC0, 4'hE);
        wait_cycle(16);  lit("f0_units",  8'h40, 4'hD);
        wait_cycle(26);  lit("f0_tens",   8'hFF, 4'hB);
        wait_cycle(40);  chk("tick_first", frame_tick, 1'b1);
        wait_cycle(41);  chk("tick_after", frame_tick, 1'b0);

        // Frame 1: 0235; change the input mid units slot.
        wait_cycle(44);  lit("f1_tenths", 8'h92, 4'hE);
        wait_cycle(54);  lit("f1_units",  8'h30, 4'hD);
        wait_cycle(55);  temperature = 16'h0999;
        wait_cycle(64);  lit("f1_tens_held", 8'hA4, 4'hB);
        wait_cycle(74);  lit("f1_sign",   8'hFF, 4'h7);
        wait_cycle(84);  lit("f2_tenths_new", 8'h90, 4'hE);

        // Negative value with blanked tens.
        wait_cycle(100); temperature = 16'h1058;
        wait_cycle(124); lit("f3_tenths", 8'h80, 4'hE);
        wait_cycle(130); temperature = 16'h2A3C;
        wait_cycle(134); lit("f3_units",  8'h12, 4'hD);
        wait_cycle(144); lit("f3_tens",   8'hFF, 4'hB);
        wait_cycle(154); lit("f3_sign",   8'hBF, 4'h7);

        // Out-of-range nibbles show 'E'.
        wait_cycle(164); lit("f4_tenths", 8'h86, 4'hE);
        wait_cycle(174); lit("f4_units",  8'h30, 4'hD);
        wait_cycle(184); lit("f4_tens",   8'h86, 4'hB);
        wait_cycle(194); lit("f4_sign",   8'h86, 4'h7);

        // Reset during cnt=7, idx=2.
        wait_cycle(227);
        rst = 1'b1;
        @(negedge clk);
        lit("rst_mid", 8'hFF, 4'hF);
        chk("rst_mid_tick", frame_tick, 1'b0);
        rst = 1'b0;
        wait_cycle(6);   lit("post_rst_tenths", 8'hC0, 4'hE);
        wait_cycle(16);  lit("post_rst_units",  8'h40, 4'hD);

        // Randomised words, change times and occasional resets.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(3, 25)) @(negedge clk);
            temperature = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (FRAME + 5) @(negedge clk);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_temp_seg7_scan

// File: doc/temp_seg7_scan.md
Name: temp_seg7_scan

Overview:
- Display stage directly downstream of the DS18B20 1-Wire driver.
- Consumes its 16-bit packed temperature word: sign nibble, tens, units and tenths digits.
- Time-multiplexes the word onto a 4-digit common-anode 7-segment display with a decimal point, minus sign, leading-zero blanking and anti-ghosting blank time.
- Samples the input once per scan frame so a word change never tears a frame.

Parameters:
- CLK_FREQ_HZ, 50000000: system clock frequency.
- SCAN_HZ, 1000: digit slot rate; SLOT_CYCLES = CLK_FREQ_HZ/SCAN_HZ; legal range SLOT_CYCLES >= 4.
- BLANK_CYCLES, 500: dead time at the start of each slot, all digits off; legal range 0 <= BLANK_CYCLES < SLOT_CYCLES.
- SEG_ACTIVE_LOW, 1: 1 = seg outputs inverted.
- DIG_ACTIVE_LOW, 1: 1 = dig outputs inverted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset.
- temperature, input, 16: [15:12] sign (0 = positive, 1 = negative), [11:8] tens, [7:4] units, [3:0] tenths; packed-digit nibbles, not binary.
- seg, output, 8: bit0..bit6 = segments a..g, bit7 = dp; polarity per SEG_ACTIVE_LOW.
- dig, output, 4: dig[0] tenths (rightmost), dig[1] units, dig[2] tens, dig[3] sign; polarity per DIG_ACTIVE_LOW.
- frame_tick, output, 1: one-cycle pulse on the cycle the snapshot is reloaded.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high; no other clock domains.
- Reset values: slot counter cnt = 0, digit index idx = 0, snapshot = 16'h0000, frame_tick = 0, seg and dig all inactive (all 1s when the active-low parameters are 1).
- Slot counter: cnt counts 0..SLOT_CYCLES-1 and wraps to 0.
  - On wrap, idx increments modulo 4 (3 -> 0).
- Snapshot: on the cycle cnt == SLOT_CYCLES-1 and idx == 3, snapshot <= temperature and frame_tick = 1 in the following cycle.
  - Between reloads, the temperature input is ignored.
  - Latency from a temperature change to display: up to one frame (4*SLOT_CYCLES) plus 1 clock.
- Two-state FSM per slot:
  - BLANK while cnt < BLANK_CYCLES: dig all inactive, seg all inactive.
  - DRIVE for the rest of the slot: only dig[idx] active, seg = code of digit idx.
  - BLANK_CYCLES = 0 means DRIVE for the whole slot.
- Output timing: seg, dig and frame_tick are registered and lag cnt/idx by exactly 1 clock.
- Digit codes (active-high, before inversion):
  - Numerals: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any nibble 10..15 shows 'E' = 79 (flags an overflowed upstream digit).
- Per-digit rules:
  - idx 0: tenths code, dp off.
  - idx 1: units code, dp on (bit7 = 1).
  - idx 2: tens code; tens == 0 is blanked (00).
  - idx 3: sign 0 -> blank 00; sign 1 -> minus 40; any other sign nibble -> 'E' 79.
- Reset mid-slot: all state returns to reset values on the next clock; outputs are inactive one clock later. No partial digit may remain driven.
- temperature changing on the same cycle as the snapshot load: the value present at that clock edge is captured.

Decomposition:
- Package temp_seg7_pkg holds:
  - segment code constants SEG_0..SEG_9, SEG_E, SEG_MINUS, SEG_BLANK, SEG_DP_BIT;
  - digit index constants IDX_TENTHS, IDX_UNITS, IDX_TENS, IDX_SIGN.
- Sub-module seg7_encode: combinational nibble -> 7-bit code decoder including the 'E' rule, instantiated once.

Test Plan (sim params CLK_FREQ_HZ=100, SCAN_HZ=10 -> SLOT_CYCLES=10, BLANK_CYCLES=2; active-low outputs):
- 1. temperature=16'h0235 held for 2 frames -> DRIVE slots show dig[3] seg=FF (blank), dig[2] seg=A4, dig[1] seg=30 (3 with dp), dig[0] seg=92. Every slot starts with 2 cycles of dig=F, seg=FF.
- 2. temperature=16'h1058 -> dig[3] seg=BF (minus), dig[2] seg=FF (tens blanked), dig[1] seg=12 (5 with dp), dig[0] seg=80.
- 3. Change 16'h0235 -> 16'h0999 in the middle of the idx=1 slot -> rest of the frame still shows 0235. The new value appears from the idx=0 DRIVE slot that follows frame_tick; frame_tick is high exactly 1 cycle per 40 cycles.
- 4. temperature=16'h2A3C -> dig[3] seg=86 (E), dig[2] seg=86, dig[1] seg=30 (3 with dp), dig[0] seg=86.
- 5. Assert rst for 1 cycle at cnt=7, idx=2 -> one clock later dig=F, seg=FF, frame_tick=0. After release: cnt restarts at 0 with idx=0, and the first frame shows snapshot 0000 as blank, blank, 0 with dp (40), 0 (C0).
- 6. BLANK_CYCLES=0 build -> no inactive gap; exactly one dig bit active on every cycle after reset.
